pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the four pipeline buffers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-buffer enable (hold) and flush (bubble) controls plus the PC write enable.
- Resolves three conditions:
  - load-use hazards;
  - jumps committed at MEM/WB (the jump flag and jump address travel down to the MEM/WB buffer);
  - multi-cycle data-memory accesses.
- Sits beside the datapath. Its inputs are taken from buffer outputs.

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB buffers: load-use bubbles, jump flushes, memory wait stalls.
// Optional HAZ_PERF_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 0,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       mem_req,
    input  logic       wb_jump,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       exmem_flush,
    output logic       memwb_flush,
`ifdef HAZ_PERF_EN
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events,
`endif
    output logic       busy
);

    typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

    localparam bit              MEM_WAITS = (MEM_LAT > 0);
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);

    state_t           state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic             loadUse;
    logic             memStall;

    // $zero is hardwired, so a load targeting it can never feed a consumer.
    assign loadUse = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Stall while the access is still counting down; the cnt==0 WAIT cycle lets it advance.
    assign memStall = ((state == S_RUN) && mem_req && MEM_WAITS) ||
                      ((state == S_WAIT) && (cnt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        if (wb_jump) begin
            // The waiting access is itself flushed, so the wait is abandoned.
            nextState = S_RUN;
            nextCnt   = '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_req && MEM_WAITS) begin
                        nextState = S_WAIT;
                        nextCnt   = LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        nextCnt = cnt - CNT_W'(1);
                    end else begin
                        nextState = S_RUN;
                    end
                end
                default: begin
                    nextState = S_RUN;
                    nextCnt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (wb_jump) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (memStall) begin
            // ID/EX load is gated by exmem_en, so it holds rather than bubbles.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            busy        = (state == S_WAIT);
        end else if (state == S_WAIT) begin
            busy = 1'b1;
        end else if (loadUse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
            if (wb_jump && (flush_events != 16'hFFFF)) flush_events <= flush_events + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a MEM_LAT=3 and a MEM_LAT=0 instance share stimulus,
// each checked every cycle against a cycle-count model of the access/jump/load-use rules.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] idRs = '0, idRt = '0, exRt = '0;
    logic       idUsesRt = 1'b0, exMemread = 1'b0, memReq = 1'b0, wbJump = 1'b0;

    // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_flush, busy}
    logic [7:0] act3, act0;
`ifdef HAZ_PERF_EN
    logic [15:0] stall3, flush3, stall0, flush0;
`endif

    logic [31:0] expQ[$];
    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;
    int wc3 = 0;
    int wc0 = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
        .ex_memread(exMemread), .ex_rt(exRt), .mem_req(memReq), .wb_jump(wbJump),
        .pc_en(act3[7]), .ifid_en(act3[6]), .ifid_flush(act3[5]), .idex_flush(act3[4]),
        .exmem_en(act3[3]), .exmem_flush(act3[2]), .memwb_flush(act3[1]),
`ifdef HAZ_PERF_EN
        .stall_cycles(stall3), .flush_events(flush3),
`endif
        .busy(act3[0])
    );

    pipe_hazard_ctrl #(.MEM_LAT(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt), .id_uses_rt(idUsesRt),
        .ex_memread(exMemread), .ex_rt(exRt), .mem_req(memReq), .wb_jump(wbJump),
        .pc_en(act0[7]), .ifid_en(act0[6]), .ifid_flush(act0[5]), .idex_flush(act0[4]),
        .exmem_en(act0[3]), .exmem_flush(act0[2]), .memwb_flush(act0[1]),
`ifdef HAZ_PERF_EN
        .stall_cycles(stall0), .flush_events(flush0),
`endif
        .busy(act0[0])
    );

    // wc = cycles already spent on the current memory access (0 = no access in progress).
    task automatic model_step(input int lat, inout int wc, input logic r, input logic jmp,
                              input logic mreq, input logic lu, output logic [15:0] res);
        logic [7:0] o;
        logic [7:0] m;
        o = 8'b1100_1000;
        m = 8'hFF;
        if (r) begin
            o  = 8'b0011_0110;
            m  = 8'hFE;
            wc = 0;
        end else if (jmp) begin
            o = 8'b1111_1100;
            if (wc != 0) m = 8'hFE;
            wc = 0;
        end else if (wc == 0 && mreq && lat > 0) begin
            o  = 8'b0000_0010;
            wc = 1;
        end else if (wc != 0 && wc < lat) begin
            o  = 8'b0000_0011;
            wc = wc + 1;
        end else if (wc != 0) begin
            o  = 8'b1100_1001;
            wc = 0;
        end else if (lu) begin
            o = 8'b0001_1000;
        end
        res = {m, o};
    endtask

    task automatic drive(input logic r, input logic jmp, input logic mreq, input logic mrd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic [4:0] xrt);
        logic       lu;
        logic [15:0] e3, e0;
        @(negedge clk);
        rst = r; wbJump = jmp; memReq = mreq; exMemread = mrd;
        idRs = rs; idRt = rt; idUsesRt = ur; exRt = xrt;
        lu = mrd && (xrt != 5'd0) && ((xrt == rs) || (ur && (xrt == rt)));
        model_step(3, wc3, r, jmp, mreq, lu, e3);
        model_step(0, wc0, r, jmp, mreq, lu, e0);
        expQ.push_back({e3, e0});
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [15:0] e);
        compared++;
        if ((act & e[15:8]) !== (e[7:0] & e[15:8])) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %b expected %b (mask %b)", name, cycleNo, act, e[7:0], e[15:8]);
        end
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                cycleNo++;
                check("mlat3", act3, e[31:16]);
                check("mlat0", act0, e[15:0]);
            end
        end
    end

    initial begin : stimulus
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on rs, then $zero, then rt not read.
        drive(0, 0, 0, 1, 5'd8, 5'd0, 0, 5'd8);
        drive(0, 0, 0, 0, 5'd8, 5'd0, 0, 5'd0);
        drive(0, 0, 0, 1, 5'd0, 5'd0, 0, 5'd0);
        drive(0, 0, 0, 1, 5'd1, 5'd8, 0, 5'd8);
        drive(0, 0, 0, 1, 5'd1, 5'd8, 1, 5'd8);
        drive(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0);
        // Memory access held until release.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Jump in the second WAIT cycle aborts the access.
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Jump coincident with load-use.
        drive(0, 1, 0, 1, 5'd5, 5'd0, 0, 5'd5);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // Reset arriving mid-wait.
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
        end
        @(negedge clk);
        #2;
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
